accuracy_monitor: RTL and testbench
===================================

// Module: accuracy_monitor
// PURPOSE
//  Downstream of the DNN output layer. Captures ideal-output bits (y_out) one neuron per clock,
//  then scores each training case at its block-cycle boundary against the thresholded output vector (a_out_alln).
//  Keeps running statistics in hardware: correct flag, sliding-window count, total correct, case count and epoch.
//  Replaces bench-side bookkeeping so that FPGA runs can read accuracy directly.
// PARAMETERS
//  n_out           16     output neurons (width of a_out_alln, depth of ideal-vector assembly)
//  checklast       1000   sliding-window depth in cases (>=2)
//  cases_per_epoch 10000  cases per epoch; epoch advances when the case counter wraps
//  width           8      fixed-point width of actL (only used under ACC_MON_ARGMAX_EN)
// PORTS
//  clk            in   1                     system clock
//  reset          in   1                     synchronous, active-high
//  y_valid        in   1                     y_out/actL valid for neuron y_idx this cycle
//  y_idx          in   $clog2(n_out)         neuron index of the current y_out
//  y_out          in   1                     ideal output bit for neuron y_idx
//  actL           in   width                 unthresholded output of neuron y_idx (unsigned frac)
//  case_done      in   1                     one-cycle pulse (cycle_clk): current case complete
//  a_out_alln     in   n_out                 thresholded actual outputs, stable while case_done=1
//  case_valid     out  1                     one-cycle pulse: statistics below were just updated
//  correct        out  1                     1 if every bit of a_out_alln equals the assembled ideal vector
//  recent         out  $clog2(checklast+1)   number of correct cases among the last checklast cases
//  total_correct  out  32                    correct cases since reset, saturates at 2^32-1
//  num_train      out  32                    cases scored since reset, wraps at 2^32
//  epoch          out  16                    current epoch, starts at 1
//  epoch_done     out  1                     one-cycle pulse alongside case_valid on the last case of an epoch
// BEHAVIOUR
//  - Reset values: case_valid=0, correct=0, recent=0, total_correct=0, num_train=0, epoch=1, epoch_done=0.
//    Window buffer, pointer, case counter and ideal vector are all cleared.
//    Reset mid-case discards the partial ideal vector. Reset takes priority over all inputs.
//  - Assembly: on y_valid, yvec[y_idx]<=y_out. y_idx>=n_out is ignored. Any order is allowed.
//    An index that is never written reads as 0.
//  - Scoring: on case_done, eval = yvec, with the same-cycle y_valid write bypassed in.
//    correct_n = (a_out_alln == eval).
//    Outputs register on the next edge, so latency is 1 clk from case_done and case_valid pulses then.
//    yvec clears on the same edge; a simultaneous y_valid write belongs to the scored case.
//  - Window: flop bit-array win[checklast-1:0] with pointer wp.
//    recent <= recent - win[wp] + correct_n; win[wp] <= correct_n; wp wraps checklast-1 -> 0.
//    recent never exceeds checklast.
//  - Counters: num_train+1. total_correct+correct_n, saturating at max.
//    The epoch case counter wraps at cases_per_epoch-1 -> 0; at the wrap, epoch_done=1 and epoch+1 (epoch wraps at 2^16).
//  - case_done on consecutive cycles is legal; each pulse scores separately.
//    The second pulse sees the cleared yvec plus any bypassed write.
// CONFIGURATION
//  ACC_MON_ARGMAX_EN defined:
//    - Also tracks a running max of actL and its index per case. Ties keep the lowest index.
//    - Tracks the index of the last y_out=1.
//    - Extra output class_correct (1b, reset 0, updated with case_valid): 1 iff argmax index == ideal one-hot index
//      and at least one ideal bit was 1.
//    - The max register clears with yvec.
//  Not defined:
//    - actL is ignored and class_correct is absent.
//    - No width-based logic is generated.
// TESTING
//  Parameters for these tests: n_out=4, checklast=4, cases_per_epoch=6, width=8.
//  1) Ideal y=4'b0100 via idx 0..3, a_out_alln=4'b0100, case_done
//     -> next clk: case_valid=1, correct=1, recent=1, total_correct=1, num_train=1.
//  2) Six cases with results 1,1,0,1,1,0 -> recent sequence 1,2,2,3,3,2 (the window drops case 1 at case 5).
//     epoch_done pulses with case 6; epoch=2.
//  3) y_valid idx3=1 in the same cycle as case_done, with a_out_alln=4'b1000 and earlier bits 0 -> correct=1.
//     The next case with no y_valid and a_out_alln=0 -> correct=1 (yvec cleared).
//  4) Reset asserted after two y_valid writes, released, then case_done with a_out_alln=0
//     -> correct=1, num_train=1, epoch=1, recent=1.
//  5) ACC_MON_ARGMAX_EN: actL=10,80,80,5 and y=4'b0010 -> class_correct=1 (tie resolves to idx1).
//     With y=4'b0100 -> class_correct=0.
//  6) Force total_correct to 2^32-1 and score a correct case -> it stays 2^32-1 and num_train still increments.

Source files
------------

// File: rtl/accuracy_monitor.sv
// accuracy_monitor: scores each training case against an ideal output vector
// and keeps running accuracy statistics for readout from hardware.
// Ideal bits arrive one neuron per clock and are assembled into a vector.
// Each case_done pulse compares that vector with the thresholded outputs.
// Statistics are registered one clock later and flagged by case_valid.
// Optional feature macro: ACC_MON_ARGMAX_EN adds argmax-based class_correct.
module accuracy_monitor #(
    parameter int n_out           = 16,
    parameter int checklast       = 1000,
    parameter int cases_per_epoch = 10000,
    parameter int width           = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           y_valid,
    input  logic [$clog2(n_out)-1:0]       y_idx,
    input  logic                           y_out,
    input  logic [width-1:0]               actL,
    input  logic                           case_done,
    input  logic [n_out-1:0]               a_out_alln,
    output logic                           case_valid,
    output logic                           correct,
    output logic [$clog2(checklast+1)-1:0] recent,
    output logic [31:0]                    total_correct,
    output logic [31:0]                    num_train,
    output logic [15:0]                    epoch,
    output logic                           epoch_done
`ifdef ACC_MON_ARGMAX_EN
    ,
    output logic                           class_correct
`endif
);

    localparam int IDX_W = $clog2(n_out);
    localparam int REC_W = $clog2(checklast + 1);
    localparam int WP_W  = (checklast > 1) ? $clog2(checklast) : 1;
    localparam int CNT_W = (cases_per_epoch > 1) ? $clog2(cases_per_epoch) : 1;

    localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W + 1)'(n_out);
    localparam logic [WP_W-1:0]  WP_LAST  = WP_W'(checklast - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cases_per_epoch - 1);

    // Ideal-vector assembly
    logic [n_out-1:0] yvec_q, yvec_d;
    logic [n_out-1:0] eval_vec;
    logic             y_wr;
    logic             correct_n;

    // Sliding window and statistics
    logic [checklast-1:0] win_q, win_d;
    logic [WP_W-1:0]      wp_q, wp_d;
    logic [REC_W-1:0]     recent_q, recent_d;
    logic [31:0]          total_q, total_d;
    logic [31:0]          num_q, num_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          epoch_q, epoch_d;
    logic                 case_valid_q, case_valid_d;
    logic                 correct_q, correct_d;
    logic                 epoch_done_q, epoch_done_d;

    // Assemble the ideal vector; a write in the scoring cycle is bypassed into the compare.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        y_wr     = y_valid && ({1'b0, y_idx} < IDX_LIM);
        eval_vec = yvec_q;
        if (y_wr) begin
            eval_vec[y_idx] = y_out;
        end
        correct_n = (a_out_alln == eval_vec);
        yvec_d    = case_done ? '0 : eval_vec;
    end

    // Compute next window, counters and registered result outputs.
    always_comb begin
        win_d        = win_q;
        wp_d         = wp_q;
        recent_d     = recent_q;
        total_d      = total_q;
        num_d        = num_q;
        cnt_d        = cnt_q;
        epoch_d      = epoch_q;
        correct_d    = correct_q;
        case_valid_d = case_done;
        epoch_done_d = 1'b0;
        if (case_done) begin
            correct_d    = correct_n;
            recent_d     = recent_q - REC_W'(win_q[wp_q]) + REC_W'(correct_n);
            win_d[wp_q]  = correct_n;
            wp_d         = (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
            num_d        = num_q + 32'd1;
            if (correct_n && (total_q != 32'hFFFF_FFFF)) begin
                total_d = total_q + 32'd1;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d        = '0;
                epoch_d      = epoch_q + 16'd1;
                epoch_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State register; synchronous reset overrides every input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            // NOTE: the window array is reset because recent is derived from its contents.
            yvec_q       <= '0;
            win_q        <= '0;
            wp_q         <= '0;
            recent_q     <= '0;
            total_q      <= '0;
            num_q        <= '0;
            cnt_q        <= '0;
            epoch_q      <= 16'd1;
            case_valid_q <= 1'b0;
            correct_q    <= 1'b0;
            epoch_done_q <= 1'b0;
        end else begin
            yvec_q       <= yvec_d;
            win_q        <= win_d;
            wp_q         <= wp_d;
            recent_q     <= recent_d;
            total_q      <= total_d;
            num_q        <= num_d;
            cnt_q        <= cnt_d;
            epoch_q      <= epoch_d;
            case_valid_q <= case_valid_d;
            correct_q    <= correct_d;
            epoch_done_q <= epoch_done_d;
        end
    end

    assign case_valid    = case_valid_q;
    assign correct       = correct_q;
    assign recent        = recent_q;
    assign total_correct = total_q;
    assign num_train     = num_q;
    assign epoch         = epoch_q;
    assign epoch_done    = epoch_done_q;

`ifdef ACC_MON_ARGMAX_EN
    // Running argmax of actL and index of the last ideal 1 within the current case
    logic [width-1:0] max_val_q, max_val_d, eval_max_val;
    logic [IDX_W-1:0] max_idx_q, max_idx_d, eval_max_idx;
    logic             max_seen_q, max_seen_d, eval_max_seen;
    logic [IDX_W-1:0] one_idx_q, one_idx_d, eval_one_idx;
    logic             class_q, class_d;

    // Update running max (ties keep lowest index) and last-one index, bypassing this cycle's write.
    always_comb begin
        eval_max_val  = max_val_q;
        eval_max_idx  = max_idx_q;
        eval_max_seen = max_seen_q;
        eval_one_idx  = one_idx_q;
        if (y_wr) begin
            if (!max_seen_q || (actL > max_val_q) ||
                ((actL == max_val_q) && (y_idx < max_idx_q))) begin
                eval_max_val = actL;
                eval_max_idx = y_idx;
            end
            eval_max_seen = 1'b1;
            if (y_out) begin
                eval_one_idx = y_idx;
            end
        end
        class_d    = class_q;
        max_val_d  = eval_max_val;
        max_idx_d  = eval_max_idx;
        max_seen_d = eval_max_seen;
        one_idx_d  = eval_one_idx;
        if (case_done) begin
            class_d    = (|eval_vec) && (eval_max_idx == eval_one_idx);
            max_val_d  = '0;
            max_idx_d  = '0;
            max_seen_d = 1'b0;
            one_idx_d  = '0;
        end
    end

    // Argmax state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_val_q  <= '0;
            max_idx_q  <= '0;
            max_seen_q <= 1'b0;
            one_idx_q  <= '0;
            class_q    <= 1'b0;
        end else begin
            max_val_q  <= max_val_d;
            max_idx_q  <= max_idx_d;
            max_seen_q <= max_seen_d;
            one_idx_q  <= one_idx_d;
            class_q    <= class_d;
        end
    end

    assign class_correct = class_q;
`else
    // actL has no consumer in this build.
    logic unused_actl;
    assign unused_actl = ^actL;
`endif

endmodule

// File: tb/tb_accuracy_monitor.sv
// tb_accuracy_monitor: directed tests for accuracy_monitor with
// n_out=4, checklast=4, cases_per_epoch=6, width=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_accuracy_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        y_valid;
    logic [1:0]  y_idx;
    logic        y_out;
    logic [7:0]  actL;
    logic        case_done;
    logic [3:0]  a_out_alln;
    logic        case_valid;
    logic        correct;
    logic [2:0]  recent;
    logic [31:0] total_correct;
    logic [31:0] num_train;
    logic [15:0] epoch;
    logic        epoch_done;
`ifdef ACC_MON_ARGMAX_EN
    logic        class_correct;
`endif

    int passed = 0;
    int total  = 0;

    accuracy_monitor #(
        .n_out(4), .checklast(4), .cases_per_epoch(6), .width(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .y_valid       (y_valid),
        .y_idx         (y_idx),
        .y_out         (y_out),
        .actL          (actL),
        .case_done     (case_done),
        .a_out_alln    (a_out_alln),
        .case_valid    (case_valid),
        .correct       (correct),
        .recent        (recent),
        .total_correct (total_correct),
        .num_train     (num_train),
        .epoch         (epoch),
        .epoch_done    (epoch_done)
`ifdef ACC_MON_ARGMAX_EN
        ,
        .class_correct (class_correct)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One ideal-bit write lasting one clock.
    task automatic put_y(input logic [1:0] idx, input logic val, input logic [7:0] act);
        y_valid = 1'b1;
        y_idx   = idx;
        y_out   = val;
        actL    = act;
        @(negedge clk);
        y_valid = 1'b0;
    endtask

    // One case_done pulse, optionally with a simultaneous ideal-bit write; returns after the result edge.
    task automatic score(input logic [3:0] a, input logic wr, input logic [1:0] idx, input logic val);
        case_done  = 1'b1;
        a_out_alln = a;
        y_valid    = wr;
        y_idx      = idx;
        y_out      = val;
        actL       = 8'd0;
        @(negedge clk);
        case_done  = 1'b0;
        y_valid    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [5:0] res_pat;
    logic [2:0] rec_exp [6];

    initial begin
        y_valid = 0; y_idx = 0; y_out = 0; actL = 0; case_done = 0; a_out_alln = 0;
        rec_exp = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd2};
        res_pat = 6'b011011;  // bit i = result of case i+1: 1,1,0,1,1,0
        do_reset();

        // Reset state
        check("rst_case_valid", 32'(case_valid), 32'd0);
        check("rst_correct",    32'(correct),    32'd0);
        check("rst_recent",     32'(recent),     32'd0);
        check("rst_total",      total_correct,   32'd0);
        check("rst_num_train",  num_train,       32'd0);
        check("rst_epoch",      32'(epoch),      32'd1);
        check("rst_epoch_done", 32'(epoch_done), 32'd0);

        // Test 1: ideal 0100 matches outputs 0100
        put_y(2'd0, 1'b0, 8'd0);
        put_y(2'd1, 1'b0, 8'd0);
        put_y(2'd2, 1'b1, 8'd0);
        put_y(2'd3, 1'b0, 8'd0);
        score(4'b0100, 1'b0, 2'd0, 1'b0);
        check("t1_case_valid", 32'(case_valid), 32'd1);
        check("t1_correct",    32'(correct),    32'd1);
        check("t1_recent",     32'(recent),     32'd1);
        check("t1_total",      total_correct,   32'd1);
        check("t1_num_train",  num_train,       32'd1);
        @(negedge clk);
        check("t1_valid_drop", 32'(case_valid), 32'd0);

        // Test 2: six cases 1,1,0,1,1,0 through a 4-deep window and a 6-case epoch
        do_reset();
        for (int i = 0; i < 6; i++) begin
            score(res_pat[i] ? 4'b0000 : 4'b0001, 1'b0, 2'd0, 1'b0);
            check($sformatf("t2_correct_%0d", i + 1),    32'(correct),    32'(res_pat[i]));
            check($sformatf("t2_recent_%0d", i + 1),     32'(recent),     32'(rec_exp[i]));
            check($sformatf("t2_epoch_done_%0d", i + 1), 32'(epoch_done), (i == 5) ? 32'd1 : 32'd0);
        end
        check("t2_epoch",     32'(epoch),    32'd2);
        check("t2_num_train", num_train,     32'd6);
        check("t2_total",     total_correct, 32'd4);
        @(negedge clk);
        check("t2_epoch_done_drop", 32'(epoch_done), 32'd0);

        // Test 3: bypassed write in the scoring cycle, then back-to-back pulses see a cleared vector
        score(4'b1000, 1'b1, 2'd3, 1'b1);
        check("t3_bypass_correct", 32'(correct), 32'd1);
        score(4'b0000, 1'b0, 2'd0, 1'b0);
        check("t3_cleared_correct", 32'(correct), 32'd1);
        check("t3_cleared_valid",   32'(case_valid), 32'd1);
        score(4'b1000, 1'b0, 2'd0, 1'b0);
        check("t3_stale_bit", 32'(correct), 32'd0);

        // Test 4: reset mid-case discards the partial ideal vector
        put_y(2'd0, 1'b1, 8'd0);
        put_y(2'd2, 1'b1, 8'd0);
        do_reset();
        score(4'b0000, 1'b0, 2'd0, 1'b0);
        check("t4_correct",   32'(correct), 32'd1);
        check("t4_num_train", num_train,    32'd1);
        check("t4_epoch",     32'(epoch),   32'd1);
        check("t4_recent",    32'(recent),  32'd1);

        // Test 6: total_correct saturates at 2^32-1
        force dut.total_q = 32'hFFFF_FFFF;
        #1;
        release dut.total_q;
        @(negedge clk);
        score(4'b0000, 1'b0, 2'd0, 1'b0);
        check("t6_total_sat", total_correct, 32'hFFFF_FFFF);
        check("t6_num_train", num_train,     32'd2);
        check("t6_correct",   32'(correct),  32'd1);

`ifdef ACC_MON_ARGMAX_EN
        // Test 5: argmax with a tie resolving to the lower index
        do_reset();
        check("t5_rst_class", 32'(class_correct), 32'd0);
        put_y(2'd0, 1'b0, 8'd10);
        put_y(2'd1, 1'b1, 8'd80);
        put_y(2'd2, 1'b0, 8'd80);
        put_y(2'd3, 1'b0, 8'd5);
        score(4'b0010, 1'b0, 2'd0, 1'b0);
        check("t5_class_hit", 32'(class_correct), 32'd1);
        put_y(2'd0, 1'b0, 8'd10);
        put_y(2'd1, 1'b0, 8'd80);
        put_y(2'd2, 1'b1, 8'd80);
        put_y(2'd3, 1'b0, 8'd5);
        score(4'b0100, 1'b0, 2'd0, 1'b0);
        check("t5_class_miss", 32'(class_correct), 32'd0);
        check("t5_correct",    32'(correct),       32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
